// File: rtl/mem_arbiter_rr_if.sv
// Client-side and memory-side bus bundle for the N-client cacheline arbiter.
// master = clients plus physical memory (the environment), slave = the arbiter.
interface mem_arbiter_rr_if #(
   parameter int unsigned N_CLIENTS = 3,
   parameter int unsigned S_LINE    = 256,
   parameter int unsigned IDW       = 2
);
   logic [N_CLIENTS-1:0]        mem_read;
   logic [N_CLIENTS-1:0]        mem_write;
   logic [N_CLIENTS*32-1:0]     mem_addr;
   logic [N_CLIENTS*S_LINE-1:0] mem_wdata;
   logic [N_CLIENTS-1:0]        mem_resp;
   logic [S_LINE-1:0]           mem_rdata;

   logic                        pmem_read;
   logic                        pmem_write;
   logic [31:0]                 pmem_addr;
   logic [S_LINE-1:0]           pmem_wdata;
   logic [S_LINE-1:0]           pmem_rdata;
   logic                        pmem_resp;

   logic                        busy;
   logic [IDW-1:0]              grant_id;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata, pmem_rdata, pmem_resp,
      input  mem_resp, mem_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata,
             busy, grant_id
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata, pmem_rdata, pmem_resp,
      output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata,
             busy, grant_id
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-client cacheline memory arbiter: one transaction in flight, round-robin or
// fixed priority, all memory- and client-side outputs registered.
module mem_arbiter_rr #(
   parameter int unsigned N_CLIENTS = 3,
   parameter int unsigned S_OFFSET  = 5,
   parameter int unsigned S_LINE    = 256,
   parameter bit          RR_MODE   = 1'b1,
   parameter int unsigned IDW       = 2
) (
   input logic             clk,
   input logic             rst,
   mem_arbiter_rr_if.slave bus
);

   localparam logic [31:0] ADDR_MASK = ~((32'(1) << S_OFFSET) - 32'(1));

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]       grant_q, grant_d;
   logic                 op_w_q, op_w_d;
   logic [31:0]          addr_q, addr_d;
   logic [S_LINE-1:0]    wdata_q, wdata_d;
   logic [S_LINE-1:0]    rdata_q, rdata_d;
   logic [N_CLIENTS-1:0] resp_q, resp_d;
   logic                 pmem_read_q, pmem_read_d;
   logic                 pmem_write_q, pmem_write_d;
   logic                 busy_q, busy_d;

   logic [N_CLIENTS-1:0] req;
   logic [31:0]          addr_arr  [N_CLIENTS];
   logic [S_LINE-1:0]    wdata_arr [N_CLIENTS];
   logic [IDW-1:0]       win;
   logic                 found;

   // Unpack the flat client buses into per-client views.
   always_comb begin
      req = bus.mem_read | bus.mem_write;
      for (int i = 0; i < int'(N_CLIENTS); i++) begin
         addr_arr[i]  = bus.mem_addr[32*i +: 32];
         wdata_arr[i] = bus.mem_wdata[S_LINE*i +: S_LINE];
      end
   end

   // Winner: first requester scanning upward from the start point, with wrap.
   always_comb begin : sel_p
      int unsigned    base;
      logic [IDW-1:0] idx;
      win   = '0;
      found = 1'b0;
      base  = RR_MODE ? 32'(rr_ptr_q) : 32'd0;
      for (int unsigned k = 0; k < N_CLIENTS; k++) begin
         idx = IDW'((base + k) % N_CLIENTS);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         op_w_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         resp_q       <= '0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         op_w_q       <= op_w_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         resp_q       <= resp_d;
         pmem_read_q  <= pmem_read_d;
         pmem_write_q <= pmem_write_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic; registered outputs are computed one cycle ahead of their state.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      op_w_d       = op_w_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      resp_d       = '0;
      pmem_read_d  = pmem_read_q;
      pmem_write_d = pmem_write_q;
      busy_d       = busy_q;

      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d      = win;
               op_w_d       = bus.mem_write[win];
               addr_d       = addr_arr[win] & ADDR_MASK;
               wdata_d      = wdata_arr[win];
               pmem_read_d  = ~bus.mem_write[win];
               pmem_write_d = bus.mem_write[win];
               busy_d       = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.pmem_resp) begin
               if (!op_w_q) rdata_d = bus.pmem_rdata;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
               resp_d       = N_CLIENTS'(1) << grant_q;
               state_d      = DONE;
            end
         end
         DONE: begin
            if (RR_MODE) begin
               if (grant_q == IDW'(N_CLIENTS - 1)) rr_ptr_d = '0;
               else                                rr_ptr_d = grant_q + IDW'(1);
            end
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            pmem_read_d  = 1'b0;
            pmem_write_d = 1'b0;
            busy_d       = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   assign bus.mem_resp   = resp_q;
   assign bus.mem_rdata  = rdata_q;
   assign bus.pmem_read  = pmem_read_q;
   assign bus.pmem_write = pmem_write_q;
   assign bus.pmem_addr  = addr_q;
   assign bus.pmem_wdata = wdata_q;
   assign bus.busy       = busy_q;
   assign bus.grant_id   = grant_q;

endmodule
